// File: rtl/dphy_tx_pkg.sv
// dphy_tx_pkg: shared D-PHY TX state encoding, line codes and default timings
package dphy_tx_pkg;
  typedef enum logic [2:0] {IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT} tx_state_t;
  localparam logic [7:0] SYNC_BYTE = 8'hB8;
  localparam logic [1:0] LP11 = 2'b11;
  localparam logic [1:0] LP01 = 2'b01;
  localparam logic [1:0] LP00 = 2'b00;
  localparam int T_LPX_DEF = 2;
  localparam int T_PREP_DEF = 2;
  localparam int T_ZERO_DEF = 6;
  localparam int T_TRAIL_DEF = 4;
  localparam int T_EXIT_DEF = 4;
endpackage

// File: rtl/hs_timer.sv
// hs_timer: loadable 8-bit down-counter that stops at zero and flags it
module hs_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] value,
  output logic       zero
);
  logic [7:0] count;
  // load takes priority; otherwise count down until zero is reached
  always_ff @(posedge clk or posedge rst)
    if (rst) count <= 8'h00;
    else if (load) count <= value;
    else if (count != 8'h00) count <= count - 8'h01;
  assign zero = count == 8'h00;
endmodule

// File: rtl/hs_tx_sequencer.sv
// hs_tx_sequencer: byte-clock LP->HS entry, payload and trailer sequencer for one D-PHY TX lane
module hs_tx_sequencer
  import dphy_tx_pkg::*;
#(
  parameter int T_LPX = T_LPX_DEF,
  parameter int T_PREP = T_PREP_DEF,
  parameter int T_ZERO = T_ZERO_DEF,
  parameter int T_TRAIL = T_TRAIL_DEF,
  parameter int T_EXIT = T_EXIT_DEF
) (
  input  logic       TX_BYTE_clk,
  input  logic       TX_rst,
  input  logic       TxRequestHS,
  input  logic [7:0] TxDataHS,
  output logic       TxReadyHS,
  output logic [7:0] TX_BYTE_DATA,
  output logic       Enable,
  output logic       LP_Dp,
  output logic       LP_Dn,
  output logic       Stop_State
);
  tx_state_t state, next;
  logic       zero;
  logic       en_next;
  logic [1:0] lp_next;
  logic [7:0] data_next, load_val;
  assign TxReadyHS = state == SYNC || state == DATA;
  assign Stop_State = state == IDLE;
  // next state: timed states advance on timer zero, SYNC/DATA follow the request
  always_comb begin
    next = state;
    case (state)
      IDLE:       next = TxRequestHS ? LPX : IDLE;
      LPX:        next = zero ? PREP : LPX;
      PREP:       next = zero ? ZERO : PREP;
      ZERO:       next = zero ? SYNC : ZERO;
      SYNC, DATA: next = TxRequestHS ? DATA : TRAIL;
      TRAIL:      next = zero ? EXIT : TRAIL;
      EXIT:       next = zero ? IDLE : EXIT;
      default:    next = IDLE;
    endcase
  end
  // registered outputs are decoded from the state being entered; trailer inverts last MSB
  always_comb begin
    load_val = next == LPX ? 8'(T_LPX - 1) : next == PREP ? 8'(T_PREP - 1) :
               next == ZERO ? 8'(T_ZERO - 1) : next == TRAIL ? 8'(T_TRAIL - 1) :
               next == EXIT ? 8'(T_EXIT - 1) : 8'h00;
    data_next = next == SYNC ? SYNC_BYTE : next == DATA ? TxDataHS :
                next == TRAIL ? (state == TRAIL ? TX_BYTE_DATA : {8{~TX_BYTE_DATA[7]}}) : 8'h00;
    lp_next = (next == IDLE || next == EXIT) ? LP11 : next == LPX ? LP01 : LP00;
    en_next = next == ZERO || next == SYNC || next == DATA || next == TRAIL;
  end
  hs_timer u_timer (
    .clk  (TX_BYTE_clk),
    .rst  (TX_rst),
    .load (next != state),
    .value(load_val),
    .zero (zero)
  );
  // state register
  always_ff @(posedge TX_BYTE_clk or posedge TX_rst)
    if (TX_rst) state <= IDLE;
    else state <= next;
  // serializer byte, enable and LP line drivers
  always_ff @(posedge TX_BYTE_clk or posedge TX_rst)
    if (TX_rst) begin
      TX_BYTE_DATA <= 8'h00;
      Enable <= 1'b0;
      {LP_Dp, LP_Dn} <= LP11;
    end else begin
      TX_BYTE_DATA <= data_next;
      Enable <= en_next;
      {LP_Dp, LP_Dn} <= lp_next;
    end
endmodule

// File: doc/hs_tx_sequencer.md
# hs_tx_sequencer

- Byte-clock sequencer upstream of the lane serializer in the MIPI D-PHY TX datapath.
- Accepts payload bytes over a PPI-style handshake (TxRequestHS/TxReadyHS).
- Generates the low-power-to-high-speed entry sequence (LP-11 → LP-01 → LP-00), the HS-zero run, the sync byte 0xB8, the payload and the HS trailer, then returns the lane to LP-11.
- Drives the serializer's byte input and enable directly, plus the LP single-ended line levels.

## Interface
Parameters (all in TX_BYTE_clk cycles, legal range 1..255):
- T_LPX, 2, duration of LP-01
- T_PREP, 2, duration of LP-00 (HS-prepare)
- T_ZERO, 6, number of 0x00 HS-zero bytes
- T_TRAIL, 4, number of trailer bytes
- T_EXIT, 4, LP-11 hold after HS before a new request is honoured

Ports:
- TX_BYTE_clk  in  1  byte clock; all logic on rising edge
- TX_rst  in  1  reset, asynchronous, active-high
- TxRequestHS  in  1  HS transmit request; held high for the whole burst
- TxDataHS  in  8  payload byte; bit 0 is serialized first
- TxReadyHS  out  1  byte-accept strobe
- TX_BYTE_DATA  out  8  byte to serializer (registered)
- Enable  out  1  serializer enable (registered)
- LP_Dp  out  1  LP driver level, Dp (registered)
- LP_Dn  out  1  LP driver level, Dn (registered)
- Stop_State  out  1  high in IDLE only

## Operation
States: IDLE, LPX, PREP, ZERO, SYNC, DATA, TRAIL, EXIT.
- IDLE: LP=11, Enable=0, data=0x00, Stop_State=1. TxRequestHS=1 sampled → LPX.
- LPX: LP=01, for T_LPX cycles, then → PREP.
- PREP: LP=00, for T_PREP cycles, then → ZERO.
- ZERO: LP=00, Enable=1, data=0x00, for T_ZERO cycles, then → SYNC.
- SYNC: data=0xB8 for exactly 1 cycle.
- DATA: holds the most recently accepted byte.
- TRAIL: data = trailer byte, Enable=1, for T_TRAIL cycles.
  - Trailer byte = {8{~b}}, where b is bit 7 of the last byte driven in SYNC/DATA.
  - Example: last byte 0xB8 → trailer 0x00; last byte 0x33 → trailer 0xFF.
- EXIT: LP=11, Enable=0, data=0x00, for T_EXIT cycles, then → IDLE.
- LP outputs are 00 in ZERO/SYNC/DATA/TRAIL.

Handshake:
- TxReadyHS = (state==SYNC || state==DATA); combinational decode of the state register.
- Accept: on any edge where TxReadyHS=1 and TxRequestHS=1, TX_BYTE_DATA ← TxDataHS and state → DATA.
- End of payload: on any edge where TxReadyHS=1 and TxRequestHS=0, state → TRAIL and TX_BYTE_DATA ← trailer byte.

Boundaries:
- Once LPX is entered, the sequence always runs to SYNC. A request drop in LPX/PREP/ZERO is not an abort; it yields a zero-payload burst (SYNC then TRAIL).
- A request held high through EXIT is honoured only after IDLE is reached (one IDLE cycle minimum).
- Reset mid-burst: all outputs return to reset values immediately (asynchronous) and state → IDLE. No trailer is sent.

Reset values: TX_BYTE_DATA=0x00, Enable=0, LP_Dp=1, LP_Dn=1, TxReadyHS=0, Stop_State=1, timer=0.

## Timing
- One shared down-counter (8 bits) is loaded with N−1 on state entry and decremented each cycle. The state advances on the edge where the count is 0, so every timed state lasts exactly N cycles.
- Request sampled at the end of cycle 0 → LP=01 in cycles 1..T_LPX.
- With default parameters:
  - LPX: cycles 1-2; PREP: cycles 3-4; ZERO: cycles 5-10; SYNC: cycle 11.
  - First payload byte appears on TX_BYTE_DATA in cycle 12.
- Throughput: 1 byte/cycle, no bubbles while TxRequestHS=1.
- Latency TxDataHS → TX_BYTE_DATA: 1 cycle.

## Structure
- Package dphy_tx_pkg holds:
  - the state enumeration;
  - SYNC_BYTE = 8'hB8;
  - LP line codes LP11/LP01/LP00 as 2-bit constants;
  - default timing constants, shared with the future RX-side checker.
- Sub-module hs_timer: loadable 8-bit down-counter with load, value and a zero flag.
- Everything else lives in hs_tx_sequencer: FSM, data register, trailer logic.

## Test plan
- Reset, then idle 10 cycles → LP=11, Enable=0, TX_BYTE_DATA=0x00, Stop_State=1, TxReadyHS=0 throughout.
- Defaults; request at cycle 0; payload 0x11, 0x22, 0x33; request drops in cycle 14 →
  - LP=01 in cycles 1-2, LP=00 in cycles 3-4;
  - 0x00 ×6 in cycles 5-10, 0xB8 in cycle 11;
  - 0x11/0x22/0x33 in cycles 12-14;
  - trailer 0xFF in cycles 15-18;
  - LP=11 with Enable=0 in cycles 19-22;
  - Stop_State=1 in cycle 23.
- Payload ending with 0x80 → trailer 0x00 ×T_TRAIL.
- Request pulsed for 1 cycle only → full entry sequence, 0xB8, then trailer 0x00 ×4, no payload, TxReadyHS high for exactly 1 cycle.
- Request held high through EXIT → second burst's LPX starts only after IDLE is reached; no LP=01 during EXIT.
- TX_rst asserted during cycle 13 of a burst → same cycle: Enable=0, LP=11, data=0x00; after release, IDLE with no trailer emitted.
